fetch_sequencer: RTL and testbench

Program-counter and fetch stage directly upstream of the instruction decoder. Drives the instruction-memory address and presents the fetched 9-bit instruction (opcode = instr[8:6]) to the decoder. Consumes the decoder's branch controls (AbsBranch, RelBranch, BranchInvert, BranchFlag) and the ALU flags to select the next PC. Owns the start/done run handshake with the testbench or top level.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_sequencer_branch_resolve.sv | 37 +++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [8:0] HALT_INSTR_DEF = 9'h1FF;
    localparam int         REL_OFF_W      = 4;

endpackage

// File: rtl/fetch_sequencer_branch_resolve.sv
// Branch condition evaluation and next-PC selection.
module branch_resolve
    import fetch_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic                 abs_branch,
    input  logic                 rel_branch,
    input  logic                 branch_invert,
    input  logic                 branch_flag,
    input  logic                 zero_flag,
    input  logic                 neg_flag,
    input  logic [PC_W-1:0]      prog_ctr,
    input  logic [PC_W-1:0]      abs_target,
    input  logic [REL_OFF_W-1:0] offset,
    output logic                 taken,
    output logic [PC_W-1:0]      next_pc
);

    logic            w_cond;
    logic [PC_W-1:0] w_off_sext;

    assign w_cond     = (branch_flag ? neg_flag : zero_flag) ^ branch_invert;
    assign taken      = (abs_branch | rel_branch) & w_cond;
    assign w_off_sext = {{(PC_W-REL_OFF_W){offset[REL_OFF_W-1]}}, offset};

    // abs wins if both are raised; PC arithmetic wraps silently
    always_comb begin
        next_pc = prog_ctr + PC_W'(1);
        if (taken && abs_branch) begin
            next_pc = abs_target;
        end else if (taken && rel_branch) begin
            next_pc = prog_ctr + w_off_sext;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC / fetch stage with start/done run handshake.
// Optional FETCH_PERF_COUNTERS_EN adds retired_cnt and taken_cnt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter logic [8:0]      HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic [8:0]      instr,
    input  logic            abs_branch,
    input  logic            rel_branch,
    input  logic            branch_invert,
    input  logic            branch_flag,
    input  logic            zero_flag,
    input  logic            neg_flag,
    input  logic [PC_W-1:0] abs_target,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [15:0]     retired_cnt,
    output logic [15:0]     taken_cnt,
`endif
    output logic [PC_W-1:0] prog_ctr,
    output logic            instr_valid,
    output logic            done
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_br_pc;
    logic            w_taken;
    logic            w_is_halt;
    logic            w_start_ok;

    branch_resolve #(
        .PC_W (PC_W)
    ) u_branch (
        .abs_branch    (abs_branch),
        .rel_branch    (rel_branch),
        .branch_invert (branch_invert),
        .branch_flag   (branch_flag),
        .zero_flag     (zero_flag),
        .neg_flag      (neg_flag),
        .prog_ctr      (r_pc),
        .abs_target    (abs_target),
        .offset        (instr[REL_OFF_W-1:0]),
        .taken         (w_taken),
        .next_pc       (w_br_pc)
    );

    assign w_is_halt   = (instr == HALT_INSTR);
    assign instr_valid = (r_state == RUN) && !stall && !w_is_halt;
    assign w_start_ok  = start && !stall && (r_state != RUN);
    assign prog_ctr    = r_pc;
    assign done        = (r_state == HALT);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (!stall) begin
            unique case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        w_state_nxt = RUN;
                        w_pc_nxt    = START_ADDR;
                    end
                end
                RUN: begin
                    if (w_is_halt) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_pc_nxt = w_br_pc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= START_ADDR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [15:0] r_retired;
    logic [15:0] r_taken;

    always_ff @(posedge clk) begin
        if (!rst_n || w_start_ok) begin
            r_retired <= '0;
            r_taken   <= '0;
        end else if (instr_valid) begin
            if (r_retired != 16'hFFFF) r_retired <= r_retired + 16'd1;
            if (w_taken && r_taken != 16'hFFFF) r_taken <= r_taken + 16'd1;
        end
    end

    assign retired_cnt = r_retired;
    assign taken_cnt   = r_taken;
`else
    logic w_unused;
    assign w_unused = w_start_ok;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, stall;
    logic [8:0] instr;
    logic       abs_branch, rel_branch, branch_invert, branch_flag;
    logic       zero_flag, neg_flag;
    logic [9:0] abs_target;
    logic [9:0] prog_ctr;
    logic       instr_valid, done;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [15:0] retired_cnt, taken_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .instr         (instr),
        .abs_branch    (abs_branch),
        .rel_branch    (rel_branch),
        .branch_invert (branch_invert),
        .branch_flag   (branch_flag),
        .zero_flag     (zero_flag),
        .neg_flag      (neg_flag),
        .abs_target    (abs_target),
`ifdef FETCH_PERF_COUNTERS_EN
        .retired_cnt   (retired_cnt),
        .taken_cnt     (taken_cnt),
`endif
        .prog_ctr      (prog_ctr),
        .instr_valid   (instr_valid),
        .done          (done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_br();
        abs_branch = 0; rel_branch = 0; branch_invert = 0;
        branch_flag = 0; zero_flag = 0; neg_flag = 0;
        abs_target = '0; instr = 9'h000;
    endtask

    initial begin
        rst_n = 0; start = 0; stall = 0;
        clr_br();
        tick(); tick();
        chk("rst_pc", 32'(prog_ctr), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_vld", 32'(instr_valid), 0);

        rst_n = 1; start = 1;
        tick();
        start = 0;
        #1;
        chk("run_pc0", 32'(prog_ctr), 0);
        chk("run_vld", 32'(instr_valid), 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq_pc", 32'(prog_ctr), 32'(i));
        end
        tick(); tick();
        chk("pc5", 32'(prog_ctr), 5);

        rel_branch = 1; zero_flag = 1; instr = 9'h00E;
        tick();
        chk("rel_back", 32'(prog_ctr), 3);
        clr_br();
        tick(); tick();
        rel_branch = 1; zero_flag = 0; instr = 9'h00E;
        tick();
        chk("rel_nt", 32'(prog_ctr), 6);

        clr_br();
        abs_branch = 1; branch_flag = 1; branch_invert = 1;
        neg_flag = 0; abs_target = 10'h2A0;
        tick();
        chk("abs_tk", 32'(prog_ctr), 32'h2A0);
        neg_flag = 1;
        tick();
        chk("abs_nt", 32'(prog_ctr), 32'h2A1);

        clr_br();
        abs_branch = 1; zero_flag = 1; abs_target = 10'h3FF;
        tick();
        chk("to3ff", 32'(prog_ctr), 32'h3FF);
        clr_br();
        tick();
        chk("wrap", 32'(prog_ctr), 0);
        abs_branch = 1; zero_flag = 1; abs_target = 10'h3FE;
        tick();
        clr_br();
        rel_branch = 1; zero_flag = 1; instr = 9'h007;
        tick();
        chk("rel_wrap", 32'(prog_ctr), 5);

        clr_br();
        repeat (4) tick();
        chk("pc9", 32'(prog_ctr), 9);
        instr = 9'h1FF;
        #1;
        chk("halt_vld", 32'(instr_valid), 0);
        tick();
        chk("done", 32'(done), 1);
        chk("halt_pc", 32'(prog_ctr), 9);
        tick();
        chk("halt_hold", 32'(prog_ctr), 9);
        instr = 9'h000; start = 1;
        tick();
        start = 0;
        chk("restart_pc", 32'(prog_ctr), 0);
        chk("restart_done", 32'(done), 0);

        repeat (7) tick();
        chk("pc7", 32'(prog_ctr), 7);
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        chk("mrst_pc", 32'(prog_ctr), 0);
        chk("mrst_vld", 32'(instr_valid), 0);
        tick();
        chk("idle_pc", 32'(prog_ctr), 0);

        start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        chk("pc4", 32'(prog_ctr), 4);
        stall = 1; abs_branch = 1; zero_flag = 1; abs_target = 10'h100;
        #1;
        chk("stall_vld", 32'(instr_valid), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", 32'(prog_ctr), 4);
        end
        stall = 0;
        tick();
        chk("unstall_br", 32'(prog_ctr), 32'h100);

`ifdef FETCH_PERF_COUNTERS_EN
        clr_br();
        rst_n = 0;
        tick();
        rst_n = 1; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 10; i++) begin
            clr_br();
            if (i == 2 || i == 5 || i == 8) begin
                rel_branch = 1; zero_flag = 1; instr = 9'h001;
            end
            tick();
        end
        clr_br();
        instr = 9'h1FF;
        tick();
        chk("retired", 32'(retired_cnt), 10);
        chk("taken", 32'(taken_cnt), 3);
        chk("cnt_pc", 32'(prog_ctr), 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
